ext_int_ctrl: RTL and testbench

- Memory-mapped external interrupt controller: the device side of the CPU's interrupt line and interrupt-acknowledge write.
- Captures edge events on external request inputs and from a one-shot countdown, holds them as pending, and drives the registered `interrupt` output into `mips`.
- Interrupt drops when the handler writes the ACK word at 0x7f20.
- Sits on the data bus next to DM, decoded from the same address/byteen the CPU emits.

---
 rtl/ext_int_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ext_int_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: memory-mapped external interrupt controller.
// Captures edges on irq_src and a one-shot countdown expiry as pending bits,
// drives a registered interrupt line to the CPU, and drops it on an ACK
// write to the PEND register, followed by a short forced-low holdoff.
// Optional feature macro: EXT_INT_CTRL_LEVEL_EN (level-sensitive sources).
module ext_int_ctrl #(
    parameter int          NUM_SRC        = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h00007f20,
    parameter int          HOLDOFF_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic [3:0]         byteen,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               interrupt
);

    localparam int PW = NUM_SRC + 1;
    // Last holdoff count value before returning to IDLE.
    localparam logic [3:0] HOLD_LAST = (HOLDOFF_CYCLES == 0) ? 4'd0 : 4'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERTED = 2'd1,
        ST_HOLDOFF  = 2'd2
    } state_t;

    // Replace the bytes of old_v selected by be with the matching bytes of new_v.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [PW-1:0]  r_pending;
    logic [PW-1:0]  r_mask;
    logic [31:0]    r_count;
    logic [3:0]     r_hold;
    logic           r_interrupt;
    state_t         r_state;

    state_t         w_state_nxt;
    logic [3:0]     w_hold_nxt;
    logic [31:0]    w_word_addr;
    logic           w_sel_pend;
    logic           w_sel_mask;
    logic           w_sel_cnt;
    logic           w_wr;
    logic           w_ack;
    logic           w_expire;
    logic [NUM_SRC-1:0] w_src_set;
    logic [PW-1:0]  w_set;
    logic [PW-1:0]  w_clr;
    logic [31:0]    w_mask_merged;

    // Address bits [1:0] are don't-care: decode on the word address only.
    assign w_word_addr   = addr & 32'hFFFF_FFFC;
    assign w_sel_pend    = (w_word_addr == BASE_ADDR);
    assign w_sel_mask    = (w_word_addr == (BASE_ADDR + 32'd4));
    assign w_sel_cnt     = (w_word_addr == (BASE_ADDR + 32'd8));
    assign w_wr          = (byteen != 4'b0000);
    assign w_ack         = w_wr & w_sel_pend;
    // Expiry is the 1->0 step; a same-cycle COUNT write does not suppress it.
    assign w_expire      = (r_count == 32'd1);
    assign w_mask_merged = byte_merge(32'(r_mask), wdata, byteen);

`ifdef EXT_INT_CTRL_LEVEL_EN
    // Level mode: a high source keeps re-setting its pending bit every cycle.
    assign w_src_set = irq_src;
`else
    logic [NUM_SRC-1:0] r_irq_prev;

    assign w_src_set = irq_src & ~r_irq_prev;

    // Previous-cycle copy of the sources for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_prev <= {NUM_SRC{1'b0}};
        end else begin
            r_irq_prev <= irq_src;
        end
    end
`endif

    assign w_set = {w_expire, w_src_set};
    assign w_clr = w_ack ? wdata[PW-1:0] : {PW{1'b0}};

    // Pending bits: clear by ACK first, then OR in new events so set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= {PW{1'b0}};
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Mask register, byte-merged; bytes beyond PW bits fall away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= {PW{1'b1}};
        end else if (w_wr && w_sel_mask) begin
            r_mask <= w_mask_merged[PW-1:0];
        end else begin
            r_mask <= r_mask;
        end
    end

    // One-shot countdown: load on write, otherwise decrement toward zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 32'd0;
        end else if (w_wr && w_sel_cnt) begin
            r_count <= byte_merge(r_count, wdata, byteen);
        end else if (r_count != 32'd0) begin
            r_count <= r_count - 32'd1;
        end else begin
            r_count <= r_count;
        end
    end

    // Next-state logic for the interrupt handshake FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if ((r_pending & r_mask) != {PW{1'b0}}) begin
                    w_state_nxt = ST_ASSERTED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ASSERTED: begin
                if (w_ack) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_HOLDOFF;
                        w_hold_nxt  = 4'd0;
                    end
                end else begin
                    w_state_nxt = ST_ASSERTED;
                end
            end
            ST_HOLDOFF: begin
                if (r_hold == HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = 4'd0;
                end else begin
                    w_state_nxt = ST_HOLDOFF;
                    w_hold_nxt  = r_hold + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = 4'd0;
            end
        endcase
    end

    // FSM state, holdoff counter and registered interrupt output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_hold      <= 4'd0;
            r_interrupt <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_interrupt <= (w_state_nxt == ST_ASSERTED);
        end
    end

    assign interrupt = r_interrupt;

    // Combinational register read mux.
    always_comb begin
        rdata = 32'd0;
        if (w_sel_pend) begin
            rdata = 32'(r_pending);
        end else if (w_sel_mask) begin
            rdata = 32'(r_mask);
        end else if (w_sel_cnt) begin
            rdata = r_count;
        end else begin
            rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Testbench for ext_int_ctrl (default build, edge-triggered sources).
module tb_ext_int_ctrl;

    localparam logic [31:0] A_P = 32'h00007f20;
    localparam logic [31:0] A_M = 32'h00007f24;
    localparam logic [31:0] A_C = 32'h00007f28;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  irq_src;
    logic        interrupt;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  src;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[40];
    vec_t hand[20];
    int   total = 0;
    int   bad   = 0;

    ext_int_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .byteen    (byteen),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq_src   (irq_src),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, push expectations, compare mid-cycle, advance.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        addr    = v.addr;
        byteen  = v.be;
        wdata   = v.wdata;
        irq_src = v.src;
        e.name  = v.name;
        e.rdata = v.exp_rdata;
        e.irq   = v.exp_irq;
        sb_q.push_back(e);
        #2;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check({got.name, "_rdata"}, rdata, got.rdata);
            check({got.name, "_irq"}, 32'(interrupt), 32'(got.irq));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            name            addr          be     wdata          src      rdata          irq
        tbl[0]  = '{"rst_pend",      A_P,          4'h0, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[1]  = '{"rst_mask",      32'h7f26,     4'h0, 32'h0,         4'h0, 32'h1F,        1'b0};
        tbl[2]  = '{"rst_cnt",       A_C,          4'h0, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[3]  = '{"edge_src2",     A_P,          4'h0, 32'h0,         4'h4, 32'h0,         1'b0};
        tbl[4]  = '{"pend_set",      A_P,          4'h0, 32'h0,         4'h0, 32'h4,         1'b0};
        tbl[5]  = '{"irq_on",        A_P,          4'h0, 32'h0,         4'h0, 32'h4,         1'b1};
        tbl[6]  = '{"ack_src2",      A_P,          4'hf, 32'h4,         4'h0, 32'h4,         1'b1};
        tbl[7]  = '{"ack_drop",      A_P,          4'h0, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[8]  = '{"holdoff1",      A_P,          4'h0, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[9]  = '{"idle_low",      A_P,          4'h0, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[10] = '{"mask_wr1",      A_M,          4'hf, 32'h1,         4'h0, 32'h1F,        1'b0};
        tbl[11] = '{"mask_src1",     A_M,          4'h0, 32'h0,         4'h2, 32'h1,         1'b0};
        tbl[12] = '{"masked_pend",   A_P,          4'h0, 32'h0,         4'h0, 32'h2,         1'b0};
        tbl[13] = '{"masked_low",    A_P,          4'h0, 32'h0,         4'h0, 32'h2,         1'b0};
        tbl[14] = '{"mask_wr3",      A_M,          4'hf, 32'h3,         4'h0, 32'h1,         1'b0};
        tbl[15] = '{"unmask_wait",   A_P,          4'h0, 32'h0,         4'h0, 32'h2,         1'b0};
        tbl[16] = '{"unmask_irq",    A_P,          4'h0, 32'h0,         4'h0, 32'h2,         1'b1};
        tbl[17] = '{"ack_src1",      A_P,          4'hf, 32'h2,         4'h0, 32'h2,         1'b1};
        tbl[18] = '{"ack2_drop",     A_P,          4'h0, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[19] = '{"mask_restore",  A_M,          4'h1, 32'hFFFF_FF1F, 4'h0, 32'h3,         1'b0};
        tbl[20] = '{"mask_all",      A_M,          4'h0, 32'h0,         4'h0, 32'h1F,        1'b0};
        tbl[21] = '{"cnt_wr5",       A_C,          4'hf, 32'h5,         4'h0, 32'h0,         1'b0};
        tbl[22] = '{"cnt5",          A_C,          4'h0, 32'h0,         4'h0, 32'h5,         1'b0};
        tbl[23] = '{"cnt4",          A_C,          4'h0, 32'h0,         4'h0, 32'h4,         1'b0};
        tbl[24] = '{"cnt3",          A_C,          4'h0, 32'h0,         4'h0, 32'h3,         1'b0};
        tbl[25] = '{"cnt2",          A_C,          4'h0, 32'h0,         4'h0, 32'h2,         1'b0};
        tbl[26] = '{"cnt1",          A_C,          4'h0, 32'h0,         4'h0, 32'h1,         1'b0};
        tbl[27] = '{"cnt0",          A_C,          4'h0, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[28] = '{"cnt_irq",       A_P,          4'h0, 32'h0,         4'h0, 32'h10,        1'b1};
        tbl[29] = '{"ack_cnt",       A_P,          4'hf, 32'h10,        4'h0, 32'h10,        1'b1};
        tbl[30] = '{"ack_cnt_drop",  A_P,          4'h0, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[31] = '{"hold_cnt",      A_P,          4'h0, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[32] = '{"coll_src0",     A_P,          4'h0, 32'h0,         4'h1, 32'h0,         1'b0};
        tbl[33] = '{"coll_pend",     A_P,          4'h0, 32'h0,         4'h0, 32'h1,         1'b0};
        tbl[34] = '{"coll_irq",      A_P,          4'h0, 32'h0,         4'h0, 32'h1,         1'b1};
        tbl[35] = '{"coll_ack",      A_P,          4'hf, 32'h1,         4'h1, 32'h1,         1'b1};
        tbl[36] = '{"coll_kept",     A_P,          4'h0, 32'h0,         4'h0, 32'h1,         1'b0};
        tbl[37] = '{"coll_hold",     A_P,          4'h0, 32'h0,         4'h0, 32'h1,         1'b0};
        tbl[38] = '{"coll_idle",     A_P,          4'h0, 32'h0,         4'h0, 32'h1,         1'b0};
        tbl[39] = '{"coll_reassert", A_P,          4'h0, 32'h0,         4'h0, 32'h1,         1'b1};

        // Mask change while asserted, ACK during holdoff, write-vs-expiry,
        // countdown cancel, byte-merged COUNT and an unmapped write.
        hand[0]  = '{"asrt_mask0",   A_M,          4'hf, 32'h0,         4'h0, 32'h1F,        1'b1};
        hand[1]  = '{"mask0_hold",   A_M,          4'h0, 32'h0,         4'h0, 32'h0,         1'b1};
        hand[2]  = '{"ack_masked",   A_P,          4'hf, 32'h1,         4'h0, 32'h1,         1'b1};
        hand[3]  = '{"hold_src3",    A_P,          4'h0, 32'h0,         4'h8, 32'h0,         1'b0};
        hand[4]  = '{"ack_in_hold",  A_P,          4'hf, 32'h8,         4'h0, 32'h8,         1'b0};
        hand[5]  = '{"hold_clear",   A_P,          4'h0, 32'h0,         4'h0, 32'h0,         1'b0};
        hand[6]  = '{"mask_back",    A_M,          4'hf, 32'h1F,        4'h0, 32'h0,         1'b0};
        hand[7]  = '{"cnt_wr2",      A_C,          4'hf, 32'h2,         4'h0, 32'h0,         1'b0};
        hand[8]  = '{"cnt_two",      A_C,          4'h0, 32'h0,         4'h0, 32'h2,         1'b0};
        hand[9]  = '{"cnt_wr_exp",   A_C,          4'hf, 32'h7,         4'h0, 32'h1,         1'b0};
        hand[10] = '{"cnt_reload",   A_C,          4'h0, 32'h0,         4'h0, 32'h7,         1'b0};
        hand[11] = '{"exp_pend",     A_P,          4'h0, 32'h0,         4'h0, 32'h10,        1'b1};
        hand[12] = '{"cnt_cancel",   A_C,          4'hf, 32'h0,         4'h0, 32'h5,         1'b1};
        hand[13] = '{"cnt_idle",     A_C,          4'h0, 32'h0,         4'h0, 32'h0,         1'b1};
        hand[14] = '{"cnt_byte1",    A_C,          4'h2, 32'h0000_0300, 4'h0, 32'h0,         1'b1};
        hand[15] = '{"cnt_merge",    A_C,          4'h0, 32'h0,         4'h0, 32'h300,       1'b1};
        hand[16] = '{"cnt_dec",      A_C,          4'h0, 32'h0,         4'h0, 32'h2FF,       1'b1};
        hand[17] = '{"cnt_stop",     A_C,          4'hf, 32'h0,         4'h0, 32'h2FE,       1'b1};
        hand[18] = '{"other_wr",     32'h7f2c,     4'hf, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b1};
        hand[19] = '{"other_nochg",  A_M,          4'h0, 32'h0,         4'h0, 32'h1F,        1'b1};

        reset   = 1'b1;
        addr    = 32'd0;
        byteen  = 4'h0;
        wdata   = 32'd0;
        irq_src = 4'h0;
        #2;
        check("rst_irq_active", 32'(interrupt), 32'd0);
        #6;
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            apply(tbl[i]);
        end
        for (int i = 0; i < 20; i++) begin
            apply(hand[i]);
        end

        // Asynchronous reset while interrupt is high, no clock edge in between.
        addr   = A_P;
        byteen = 4'h0;
        reset  = 1'b1;
        #1;
        check("async_rst_irq", 32'(interrupt), 32'd0);
        check("async_rst_pend", rdata, 32'd0);
        addr = A_M;
        #1;
        check("async_rst_mask", rdata, 32'h1F);
        addr = A_C;
        #1;
        check("async_rst_cnt", rdata, 32'd0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
